// File: rtl/crg_cdc_bus_tx.sv
// Source-domain launcher for a multi-bit bus crossing on a 4-phase req/ack handshake.
// A word is captured from a valid/ready producer and held on xfer_data until the handshake returns to idle.
module crg_cdc_bus_tx #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,  // legal range 2..4
  parameter int TIMEOUT_CYC = 0   // 0 disables the ack-high timeout
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             src_ready,
  output logic [WIDTH-1:0] xfer_data,
  output logic             xfer_req,
  input  logic             xfer_ack,
  output logic             done,
  output logic             timeout_err,
  output logic             busy
);

  localparam int                CNT_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit                TMO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0]  CNT_LAST = TMO_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    REQ_HI,
    REQ_LO
  } state_t;

  state_t                 state;
  state_t                 state_n;
  logic                   req_n;
  logic [WIDTH-1:0]       data_n;
  logic                   done_n;
  logic                   tmo_n;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_n;
  logic                   timed_out;
  logic                   timed_out_n;
  logic                   accept;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;

  // xfer_ack is asynchronous; only the last synchronizer stage reaches the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], xfer_ack};
    end
  end

  assign ack_s     = ack_sync[SYNC_STAGES-1];
  assign src_ready = (state == IDLE) & ~reset;
  assign accept    = src_valid & src_ready;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      xfer_req    <= 1'b0;
      xfer_data   <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= '0;
      timed_out   <= 1'b0;
    end else begin
      state       <= state_n;
      xfer_req    <= req_n;
      xfer_data   <= data_n;
      done        <= done_n;
      timeout_err <= tmo_n;
      cnt         <= cnt_n;
      timed_out   <= timed_out_n;
    end
  end

  always_comb begin
    state_n     = state;
    req_n       = xfer_req;
    data_n      = xfer_data;
    done_n      = 1'b0;
    tmo_n       = 1'b0;
    cnt_n       = cnt;
    timed_out_n = timed_out;
    case (state)
      IDLE: begin
        if (accept) begin
          data_n      = src_data;
          timed_out_n = 1'b0;
          state_n     = SETUP;
        end
      end
      // One cycle of data setup ahead of the request edge.
      SETUP: begin
        req_n   = 1'b1;
        cnt_n   = '0;
        state_n = REQ_HI;
      end
      // A stale ack already high on entry is accepted as the acknowledge.
      REQ_HI: begin
        if (ack_s) begin
          req_n   = 1'b0;
          state_n = REQ_LO;
        end else if (TMO_EN && (cnt == CNT_LAST)) begin
          req_n       = 1'b0;
          tmo_n       = 1'b1;
          timed_out_n = 1'b1;
          state_n     = REQ_LO;
        end else if (cnt != CNT_MAX) begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      // No timeout here: never re-request while the destination still holds ack.
      REQ_LO: begin
        if (!ack_s) begin
          done_n  = ~timed_out;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_crg_cdc_bus_tx.sv
// Directed bench for crg_cdc_bus_tx: transaction-level reference checked every cycle,
// plus literal latency/pulse-count expectations for each scenario.
module tb_crg_cdc_bus_tx;

  localparam int WIDTH = 16;
  localparam int SYNC  = 2;
  localparam int TMO   = 8;
  localparam int HN    = 1024;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             src_valid = 1'b0;
  logic [WIDTH-1:0] src_data = '0;
  logic             src_ready;
  logic [WIDTH-1:0] xfer_data;
  logic             xfer_req;
  logic             xfer_ack = 1'b0;
  logic             done;
  logic             timeout_err;
  logic             busy;

  always #5 clk = ~clk;

  crg_cdc_bus_tx #(
    .WIDTH(WIDTH),
    .SYNC_STAGES(SYNC),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .src_valid(src_valid),
    .src_data(src_data),
    .src_ready(src_ready),
    .xfer_data(xfer_data),
    .xfer_req(xfer_req),
    .xfer_ack(xfer_ack),
    .done(done),
    .timeout_err(timeout_err),
    .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check16(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Destination responder: 0 = ack follows req after resp_delay negedges, 1 = held high, 2 = held low.
  int         ack_mode   = 2;
  int         resp_delay = 0;
  logic [7:0] resp_pipe  = '0;

  initial begin
    forever begin
      @(negedge clk);
      resp_pipe = {resp_pipe[6:0], xfer_req};
      case (ack_mode)
        0:       xfer_ack = resp_pipe[resp_delay];
        1:       xfer_ack = 1'b1;
        default: xfer_ack = 1'b0;
      endcase
    end
  end

  // Reference: the ack the launcher may react to at edge e is the pin value at edge e-SYNC,
  // provided that sample was taken after the most recent reset edge.
  bit               ack_hist [HN];
  int               cyc = 0;
  int               last_rst = 0;
  bit               a_s;
  bit               m_active = 0, m_req = 0, m_drain = 0, m_was_tmo = 0, m_done = 0, m_tmo = 0;
  logic [WIDTH-1:0] m_data = '0;
  int               m_t0 = 0;

  // Observed DUT events
  int   req_rise = 0, req_fall = 0, acc_last = 0, done_last = 0;
  int   acc_cnt = 0, done_cnt = 0, tmo_cnt = 0;
  logic prev_req = 1'b0, prev_busy = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      a_s = 1'b0;
      if (cyc - SYNC > last_rst) a_s = ack_hist[(cyc - SYNC) % HN];
      ack_hist[cyc % HN] = reset ? 1'b0 : xfer_ack;
      m_done = 1'b0;
      m_tmo  = 1'b0;
      if (reset) begin
        last_rst = cyc;
        m_active = 1'b0;
        m_req    = 1'b0;
        m_drain  = 1'b0;
        m_data   = '0;
      end else if (!m_active) begin
        if (src_valid) begin
          m_active  = 1'b1;
          m_data    = src_data;
          m_t0      = cyc;
          m_req     = 1'b0;
          m_drain   = 1'b0;
          m_was_tmo = 1'b0;
        end
      end else if (!m_req && !m_drain) begin
        m_req = 1'b1;
      end else if (m_req) begin
        if (a_s) begin
          m_req   = 1'b0;
          m_drain = 1'b1;
        end else if (TMO != 0 && (cyc - (m_t0 + 1)) == TMO) begin
          m_req     = 1'b0;
          m_drain   = 1'b1;
          m_tmo     = 1'b1;
          m_was_tmo = 1'b1;
        end
      end else if (!a_s) begin
        m_active = 1'b0;
        m_drain  = 1'b0;
        m_done   = !m_was_tmo;
      end
      #1;
      check1("xfer_req", xfer_req, m_req);
      check16("xfer_data", xfer_data, m_data);
      check1("done", done, m_done);
      check1("timeout_err", timeout_err, m_tmo);
      check1("busy", busy, m_active);
      check1("src_ready", src_ready, !m_active && !reset);
      if (xfer_req && !prev_req) req_rise = cyc;
      if (!xfer_req && prev_req) req_fall = cyc;
      if (busy && !prev_busy) begin
        acc_last = cyc;
        acc_cnt++;
      end
      if (done) begin
        done_last = cyc;
        done_cnt++;
      end
      if (timeout_err) tmo_cnt++;
      prev_req  = xfer_req;
      prev_busy = busy;
    end
  end

  task automatic wait_done(input string name, input int limit, input bit scramble);
    bit seen = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (scramble) begin
        src_data  = WIDTH'($urandom);
        src_valid = 1'($urandom);
      end
    end
    src_valid = 1'b0;
    check1(name, seen, 1'b1);
  endtask

  task automatic launch(input logic [WIDTH-1:0] d);
    src_valid = 1'b1;
    src_data  = d;
    @(negedge clk);
    src_valid = 1'b0;
  endtask

  initial begin
    int base_d, base_t, base_a;
    bit hit;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check1("rst_req", xfer_req, 1'b0);
    check16("rst_data", xfer_data, 16'h0000);
    check1("rst_busy", busy, 1'b0);
    check1("rst_ready", src_ready, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_tmo", timeout_err, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check1("ready_after_rst", src_ready, 1'b1);

    // Single transfer, responder one cycle behind, src side scrambled while busy
    ack_mode = 0; resp_delay = 1; base_d = done_cnt;
    launch(16'hA5C3);
    wait_done("single_done", 40, 1'b1);
    checki("single_latency", done_last - acc_last, 9);
    checki("single_req_after_acc", req_rise - acc_last, 1);
    checki("single_req_len", req_fall - req_rise, 4);
    check16("single_data", xfer_data, 16'hA5C3);
    checki("single_done_cnt", done_cnt - base_d, 1);
    check1("single_busy_low", busy, 1'b0);
    repeat (2) @(negedge clk);

    // Minimum transaction: ack follows req immediately
    resp_delay = 0;
    launch(16'h1234);
    wait_done("min_done", 40, 1'b0);
    checki("min_latency", done_last - acc_last, 3 + 2 * SYNC);
    repeat (2) @(negedge clk);

    // Back-to-back with src_valid held
    resp_delay = 1; base_d = done_cnt; base_a = acc_cnt;
    src_valid = 1'b1; src_data = 16'h0001;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (acc_cnt - base_a == 1) src_data = 16'h0002;
      if (acc_cnt - base_a >= 2) break;
    end
    src_valid = 1'b0;
    checki("b2b_accepts", acc_cnt - base_a, 2);
    checki("b2b_gap", acc_last - done_last, 1);
    check16("b2b_data2", xfer_data, 16'h0002);
    wait_done("b2b_done2", 40, 1'b0);
    checki("b2b_done_cnt", done_cnt - base_d, 2);
    repeat (2) @(negedge clk);

    // Timeout: destination never acks
    ack_mode = 2; base_d = done_cnt; base_t = tmo_cnt;
    launch(16'hBEEF);
    hit = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (timeout_err) begin
        hit = 1'b1;
        break;
      end
    end
    check1("tmo_seen", hit, 1'b1);
    checki("tmo_req_len", req_fall - req_rise, TMO);
    repeat (5) @(negedge clk);
    check1("tmo_idle", busy, 1'b0);
    checki("tmo_cnt", tmo_cnt - base_t, 1);
    checki("tmo_no_done", done_cnt - base_d, 0);
    check16("tmo_data", xfer_data, 16'hBEEF);

    // Stale ack already high before the accept
    ack_mode = 1;
    repeat (4) @(negedge clk);
    base_d = done_cnt; base_t = tmo_cnt;
    launch(16'h5A5A);
    repeat (12) @(negedge clk);
    checki("stale_req_len", req_fall - req_rise, 1);
    check1("stale_busy_held", busy, 1'b1);
    checki("stale_no_done_yet", done_cnt - base_d, 0);
    ack_mode = 2;
    wait_done("stale_done", 20, 1'b0);
    checki("stale_done_cnt", done_cnt - base_d, 1);
    checki("stale_no_tmo", tmo_cnt - base_t, 0);
    repeat (3) @(negedge clk);

    // Reset while in REQ_HI with ack high
    base_d = done_cnt; base_t = tmo_cnt;
    launch(16'hC0C0);
    for (int k = 0; k < 10; k++) begin
      if (xfer_req) break;
      @(negedge clk);
    end
    check1("rmid_in_req_hi", xfer_req, 1'b1);
    ack_mode = 1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check1("rmid_req_dropped", xfer_req, 1'b0);
    check1("rmid_busy", busy, 1'b0);
    check1("rmid_ready_in_rst", src_ready, 1'b0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check1("rmid_ready_after", src_ready, 1'b1);
    check1("rmid_idle_with_ack", busy, 1'b0);
    checki("rmid_no_done", done_cnt - base_d, 0);
    checki("rmid_no_tmo", tmo_cnt - base_t, 0);
    ack_mode = 0; resp_delay = 0;
    repeat (4) @(negedge clk);
    launch(16'hC0DE);
    wait_done("rmid_new_done", 40, 1'b0);
    check16("rmid_new_data", xfer_data, 16'hC0DE);
    checki("rmid_new_latency", done_last - acc_last, 3 + 2 * SYNC);
    checki("rmid_done_cnt", done_cnt - base_d, 1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
